pipe_skid_reg: RTL

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_skid_reg.sv
// Two-entry pipeline stage register with a skid buffer, flush-to-nop and a
// saturating count of squashed entries. in_ready comes straight from a flop.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | main entry valid, skid free
// TWO   | main and skid valid, upstream stalled
module pipe_skid_reg #(
  parameter int DATA_W         = 16,
  parameter int CTRL_W         = 11,
  parameter int CNT_W          = 8,
  parameter bit ZERO_ON_BUBBLE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W+1:0] CNT_MAX = {2'b00, {CNT_W{1'b1}}};

  state_t            state, state_nxt;
  logic              in_ready_q;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CNT_W-1:0]  drop_q;

  logic              accept, pop;
  logic              load_main, load_skid, move_skid;
  logic [1:0]        drop_inc;
  logic [CNT_W+1:0]  drop_sum;
  logic [CNT_W-1:0]  drop_nxt;

  assign in_ready  = in_ready_q;
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid & in_ready_q;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_nxt = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_main = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          move_skid = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // A flush squashes everything, including whatever was accepted this cycle.
    if (flush) begin
      state_nxt = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  // Squashed entries: main not popped, skid, and the incoming word.
  always_comb begin
    drop_inc = 2'(out_valid & ~out_ready) + 2'(state == TWO) + 2'(accept);
    drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, drop_inc};
    drop_nxt = (drop_sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
      main_ctrl  <= '0;
      main_data  <= '0;
      drop_q     <= '0;
    end else begin
      state      <= state_nxt;
      in_ready_q <= (state_nxt != TWO);
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (move_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (flush) begin
        drop_q <= drop_nxt;
      end
    end
  end

  // Skid payload is only meaningful in TWO, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_ctrl <= in_ctrl;
      skid_data <= in_data;
    end
  end

  assign drop_count = drop_q;

  generate
    if (ZERO_ON_BUBBLE) begin : g_zero
      assign out_ctrl = out_valid ? main_ctrl : '0;
      assign out_data = out_valid ? main_data : '0;
    end else begin : g_hold
      assign out_ctrl = main_ctrl;
      assign out_data = main_data;
    end
  endgenerate

endmodule
